// File: rtl/enc_pkg.sv
// Shared constants, register map and decoder state type for the encoder
// front end and its read-only SPI register bank.
package enc_pkg;

  // Identification word returned at the global ID address.
  localparam logic [31:0] ENC_ID = 32'h454E_4301;

  // Field offsets inside a per-channel block (addr[3:0]).
  localparam logic [3:0] FLD_POS   = 4'h0;
  localparam logic [3:0] FLD_SPEED = 4'h1;
  localparam logic [3:0] FLD_ERR   = 4'h2;
  localparam logic [3:0] FLD_RAW   = 4'h3;

  // Global registers living in block 0.
  localparam logic [7:0] ADDR_ID     = 8'h00;
  localparam logic [7:0] ADDR_WINSEQ = 8'h01;
  localparam logic [7:0] ADDR_NENC   = 8'h02;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dec_state_t;

  // Map the Gray sequence 00,01,11,10 onto 0,1,2,3 so a forward step is
  // a +1 difference modulo 4, a reverse step -1 and an illegal jump 2.
  function automatic logic [1:0] gray_to_idx(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// One quadrature channel: 2-flop synchronizer, glitch filter, INIT/RUN x4
// decoder and the signed position / error counters.
// ENC_ERRCNT_EN: when defined, illegal transitions are counted in err;
// otherwise err is tied to zero and no counter is built.
module quad_decoder
  import enc_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               clr,
  output logic signed [31:0] pos,
  output logic        [15:0] err,
  output logic               filt_a,
  output logic               filt_b
);

  localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

  logic [1:0]      sync_p0;
  logic [1:0]      sync_p1;
  logic [1:0]      filt_p2;
  logic [1:0][3:0] flt_cnt;
  logic [1:0]      prev_ab;
  logic [1:0]      warm_cnt;
  logic            settled;
  logic [1:0]      idx_diff;
  dec_state_t      state_q;
  dec_state_t      state_d;
  logic            step_inc;
  logic            step_dec;
  logic            step_bad;

  assign filt_a = filt_p2[1];
  assign filt_b = filt_p2[0];

  // Stage p0/p1: double-flop the asynchronous {A,B} pins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {enc_a, enc_b};
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: a level change is accepted after FILTER_LEN consecutive
  // synchronized samples that disagree with the current filtered level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      filt_p2 <= '0;
      flt_cnt <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sync_p1[k] == filt_p2[k]) begin
          flt_cnt[k] <= '0;
        end else if (flt_cnt[k] == FLT_LAST) begin
          filt_p2[k] <= sync_p1[k];
          flt_cnt[k] <= '0;
        end else begin
          flt_cnt[k] <= flt_cnt[k] + 4'd1;
        end
      end
    end
  end

  // Count the cycles needed to fill the synchronizer after reset, so the
  // decoder never locks onto the reset value of an empty pipeline.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      warm_cnt <= '0;
    end else if (warm_cnt != 2'd2) begin
      warm_cnt <= warm_cnt + 2'd1;
    end
  end

  assign settled  = (warm_cnt == 2'd2) && (sync_p1 == filt_p2);
  assign idx_diff = gray_to_idx(filt_p2) - gray_to_idx(prev_ab);

  // Decoder state and previous filtered levels; prev always tracks the
  // filtered input so INIT loads it and RUN compares against it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= INIT;
      prev_ab <= '0;
    end else begin
      state_q <= state_d;
      prev_ab <= filt_p2;
    end
  end

  // Next state and step classification.
  always_comb begin
    state_d  = state_q;
    step_inc = 1'b0;
    step_dec = 1'b0;
    step_bad = 1'b0;
    case (state_q)
      INIT: begin
        if (settled) state_d = RUN;
      end
      RUN: begin
        case (idx_diff)
          2'd1:    step_inc = 1'b1;
          2'd3:    step_dec = 1'b1;
          2'd2:    step_bad = 1'b1;
          default: ;
        endcase
      end
      default: state_d = INIT;
    endcase
  end

  // Position counter: clear wins, otherwise wrap-around +/-1.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (step_inc) begin
      pos <= pos + 32'sd1;
    end else if (step_dec) begin
      pos <= pos - 32'sd1;
    end
  end

`ifdef ENC_ERRCNT_EN
  function automatic logic [15:0] err_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Illegal-transition counter, saturating at all ones.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      err <= '0;
    end else if (clr) begin
      err <= '0;
    end else if (step_bad) begin
      err <= err_sat_inc(err);
    end
  end
`else
  logic unused_step_bad;
  assign unused_step_bad = step_bad;
  assign err             = '0;
`endif

endmodule

// File: rtl/enc_reg_bank.sv
// Quadrature encoder front end plus read-only register bank for the SPI
// link. Holds the shared speed window, per-channel Base/Speed, WinSeq and
// the registered read mux feeding DataToRPi.
// ENC_ERRCNT_EN: when defined, per-channel illegal-transition counters are
// built and readable at field 2; otherwise field 2 reads zero.
module enc_reg_bank
  import enc_pkg::*;
#(
  parameter int NUM_ENC      = 2,
  parameter int SPEED_WINDOW = 50000,
  parameter int FILTER_LEN   = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_ENC-1:0] EncA,
  input  logic [NUM_ENC-1:0] EncB,
  input  logic [NUM_ENC-1:0] ClrCount,
  input  logic [31:0]        DataAddr,
  output logic [31:0]        DataToRPi
);

  localparam int                WIN_W    = $clog2(SPEED_WINDOW);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(SPEED_WINDOW - 1);
  localparam logic [3:0]        NENC4    = 4'(NUM_ENC);

  logic signed [31:0] pos   [NUM_ENC];
  logic signed [31:0] base  [NUM_ENC];
  logic signed [31:0] speed [NUM_ENC];
  logic        [15:0] err   [NUM_ENC];
  logic [NUM_ENC-1:0] filt_a;
  logic [NUM_ENC-1:0] filt_b;

  logic [WIN_W-1:0]   win_cnt;
  logic               win_term;
  logic [31:0]        win_seq;
  logic [31:0]        rd_data_p0;
  logic [3:0]         blk;
  logic [3:0]         fld;
  logic [23:0]        unused_addr_hi;

  assign unused_addr_hi = DataAddr[31:8];
  assign blk            = DataAddr[7:4];
  assign fld            = DataAddr[3:0];

  for (genvar i = 0; i < NUM_ENC; i++) begin : g_ch
    quad_decoder #(
      .FILTER_LEN(FILTER_LEN)
    ) u_dec (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .enc_a  (EncA[i]),
      .enc_b  (EncB[i]),
      .clr    (ClrCount[i]),
      .pos    (pos[i]),
      .err    (err[i]),
      .filt_a (filt_a[i]),
      .filt_b (filt_b[i])
    );
  end

  assign win_term = (win_cnt == WIN_LAST);

  // Shared window counter and window sequence number.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      win_cnt <= '0;
      win_seq <= '0;
    end else if (win_term) begin
      win_cnt <= '0;
      win_seq <= win_seq + 32'd1;
    end else begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  // Per-channel speed snapshot at each window terminal; clear wins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ENC; i++) begin
        base[i]  <= '0;
        speed[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENC; i++) begin
        if (ClrCount[i]) begin
          base[i]  <= '0;
          speed[i] <= '0;
        end else if (win_term) begin
          speed[i] <= pos[i] - base[i];
          base[i]  <= pos[i];
        end
      end
    end
  end

  // Address decode over the live register values.
  always_comb begin
    rd_data_p0 = '0;
    if (DataAddr[7:0] == ADDR_ID) begin
      rd_data_p0 = ENC_ID;
    end else if (DataAddr[7:0] == ADDR_WINSEQ) begin
      rd_data_p0 = win_seq;
    end else if (DataAddr[7:0] == ADDR_NENC) begin
      rd_data_p0 = {28'b0, NENC4};
    end else begin
      for (int i = 0; i < NUM_ENC; i++) begin
        if (blk == 4'(i + 1)) begin
          case (fld)
            FLD_POS:   rd_data_p0 = pos[i];
            FLD_SPEED: rd_data_p0 = speed[i];
            FLD_ERR:   rd_data_p0 = {16'b0, err[i]};
            FLD_RAW:   rd_data_p0 = {30'b0, filt_a[i], filt_b[i]};
            default:   rd_data_p0 = '0;
          endcase
        end
      end
    end
  end

  // Output register toward the SPI slave.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DataToRPi <= '0;
    end else begin
      DataToRPi <= rd_data_p0;
    end
  end

endmodule
